axis_multichannel_downmixer: RTL and testbench

Parametrised successor to the stereo packet-to-mono converter. Accepts interleaved multi-channel PCM frames on an AXI4-Stream slave (one beat per channel, TLAST on the final channel) and produces one mono sample per frame. The sample is either the arithmetic average of all channels or one selected channel. Sits between the I2S/DMA stream and the FFT/visualizer front end, with full-throughput handshaking on both sides and detection of framing errors.

---
 rtl/axis_multichannel_downmixer.sv | 166 ++++++++++++++++
 tb/tb_axis_multichannel_downmixer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_multichannel_downmixer.sv
// Multi-channel AXI4-Stream to mono downmixer: averages or selects one
// channel per TLAST-delimited frame and flags framing errors.
// Ports: S_AXIS_* slave stream in, mix_mode/sel_channel control,
// mono_sample_* valid/ready output, frame_error pulse, err_count counter.
module axis_multichannel_downmixer #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_CHANNELS   = 2,
  parameter bit SIGNED_SAMPLES = 1'b1
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESETN,
  input  logic                  S_AXIS_TVALID,
  input  logic                  S_AXIS_TLAST,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  output logic                  S_AXIS_TREADY,
  input  logic                  mix_mode,
  input  logic [3:0]            sel_channel,
  input  logic                  mono_sample_ready,
  output logic                  mono_sample_valid,
  output logic [DATA_WIDTH-1:0] mono_sample,
  output logic                  frame_error,
  output logic [15:0]           err_count
);

  localparam int LOGN = $clog2(NUM_CHANNELS);
  localparam int CW   = (LOGN > 0) ? LOGN : 1;
  localparam int AW   = DATA_WIDTH + LOGN;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CHANNELS - 1);
  localparam logic [4:0]    NCH      = 5'(NUM_CHANNELS);

  typedef enum logic {
    COLLECT,
    DISCARD
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         beat_cnt, beat_cnt_nxt;
  logic [AW-1:0]         acc, acc_nxt, ext;
  logic                  mode_q, mode_eff;
  logic [3:0]            chan_q, chan_in, chan_eff;
  logic [DATA_WIDTH-1:0] pick_q, pick_nxt, avg, result;
  logic                  accept, first, at_last;
  logic                  load, err_hit;

  assign first   = (beat_cnt == '0);
  assign at_last = (beat_cnt == LAST_IDX);

  // Stall only the closing beat of a frame while the previous
  // result still waits downstream.
  always_comb begin
    S_AXIS_TREADY = 1'b0;
    if (S_AXIS_ARESETN) begin
      if (state == DISCARD)
        S_AXIS_TREADY = 1'b1;
      else
        S_AXIS_TREADY = !(at_last && mono_sample_valid
                          && !mono_sample_ready);
    end
  end

  assign accept = S_AXIS_TVALID && S_AXIS_TREADY;

  always_comb begin
    if (SIGNED_SAMPLES)
      ext = AW'($signed(S_AXIS_TDATA));
    else
      ext = AW'(S_AXIS_TDATA);
  end

  assign acc_nxt = first ? ext : acc + ext;

  // Arithmetic shift floors signed averages toward minus infinity.
  always_comb begin
    if (SIGNED_SAMPLES)
      avg = DATA_WIDTH'($signed(acc_nxt) >>> LOGN);
    else
      avg = DATA_WIDTH'(acc_nxt >> LOGN);
  end

  // Out-of-range channel indices fall back to channel 0.
  assign chan_in  = ({1'b0, sel_channel} < NCH) ? sel_channel : 4'd0;
  assign mode_eff = first ? mix_mode : mode_q;
  assign chan_eff = first ? chan_in : chan_q;
  assign pick_nxt = (4'(beat_cnt) == chan_eff) ? S_AXIS_TDATA : pick_q;
  assign result   = mode_eff ? pick_nxt : avg;

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state    <= COLLECT;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    load         = 1'b0;
    err_hit      = 1'b0;
    unique case (state)
      COLLECT: begin
        if (accept) begin
          unique case (1'b1)
            S_AXIS_TLAST && at_last: begin
              load         = 1'b1;
              beat_cnt_nxt = '0;
            end
            S_AXIS_TLAST && !at_last: begin
              err_hit      = 1'b1;
              beat_cnt_nxt = '0;
            end
            !S_AXIS_TLAST && at_last: begin
              err_hit      = 1'b1;
              beat_cnt_nxt = '0;
              state_nxt    = DISCARD;
            end
            default: beat_cnt_nxt = beat_cnt + CW'(1);
          endcase
        end
      end
      DISCARD: begin
        beat_cnt_nxt = '0;
        if (accept && S_AXIS_TLAST)
          state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      acc    <= '0;
      pick_q <= '0;
      mode_q <= 1'b0;
      chan_q <= '0;
    end else if (accept && state == COLLECT) begin
      acc    <= acc_nxt;
      pick_q <= pick_nxt;
      if (first) begin
        mode_q <= mix_mode;
        chan_q <= chan_in;
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      mono_sample_valid <= 1'b0;
      mono_sample       <= '0;
      frame_error       <= 1'b0;
      err_count         <= '0;
    end else begin
      mono_sample_valid <= load
                           || (mono_sample_valid && !mono_sample_ready);
      if (load)
        mono_sample <= result;
      frame_error <= err_hit;
      if (err_hit && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_multichannel_downmixer.sv
// Directed bench for axis_multichannel_downmixer: N=2 signed/unsigned
// and N=4 signed instances share one stimulus bus.
module tb_axis_multichannel_downmixer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [31:0] tdata = '0;
  logic        mix_mode = 1'b0;
  logic [3:0]  sel_channel = '0;
  logic        ready = 1'b0;

  logic        tr [3];
  logic        vl [3];
  logic [31:0] mo [3];
  logic        fe [3];
  logic [15:0] ec [3];

  int dsel = 0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic        tr_m, vl_m, fe_m;
  logic [31:0] mo_m;
  logic [15:0] ec_m;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    tr_m = tr[dsel];
    vl_m = vl[dsel];
    mo_m = mo[dsel];
    fe_m = fe[dsel];
    ec_m = ec[dsel];
  end

  axis_multichannel_downmixer #(.DATA_WIDTH(32), .NUM_CHANNELS(2),
    .SIGNED_SAMPLES(1'b1)) u_n2s (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TLAST(tlast),
    .S_AXIS_TDATA(tdata), .S_AXIS_TREADY(tr[0]),
    .mix_mode(mix_mode), .sel_channel(sel_channel),
    .mono_sample_ready(ready), .mono_sample_valid(vl[0]),
    .mono_sample(mo[0]), .frame_error(fe[0]), .err_count(ec[0]));

  axis_multichannel_downmixer #(.DATA_WIDTH(32), .NUM_CHANNELS(2),
    .SIGNED_SAMPLES(1'b0)) u_n2u (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TLAST(tlast),
    .S_AXIS_TDATA(tdata), .S_AXIS_TREADY(tr[1]),
    .mix_mode(mix_mode), .sel_channel(sel_channel),
    .mono_sample_ready(ready), .mono_sample_valid(vl[1]),
    .mono_sample(mo[1]), .frame_error(fe[1]), .err_count(ec[1]));

  axis_multichannel_downmixer #(.DATA_WIDTH(32), .NUM_CHANNELS(4),
    .SIGNED_SAMPLES(1'b1)) u_n4s (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(tvalid), .S_AXIS_TLAST(tlast),
    .S_AXIS_TDATA(tdata), .S_AXIS_TREADY(tr[2]),
    .mix_mode(mix_mode), .sel_channel(sel_channel),
    .mono_sample_ready(ready), .mono_sample_valid(vl[2]),
    .mono_sample(mo[2]), .frame_error(fe[2]), .err_count(ec[2]));

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    #1;
    while (tr_m !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL send_timeout tready=%b required=1", tr_m);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
  endtask

  task automatic do_reset();
    idle();
    mix_mode = 1'b0;
    sel_channel = '0;
    ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    dsel = 2;
    do_reset();
    checks++;
    if ({vl_m, fe_m, mo_m, ec_m} !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h required=0",
               {vl_m, fe_m, mo_m, ec_m});
    end
    checks++;
    if (tr_m !== 1'b1) begin
      failures++;
      $display("FAIL reset_tready got=%b required=1", tr_m);
    end
  endtask

  task automatic test_average();
    dsel = 0;
    do_reset();
    ready = 1'b1;
    send_beat(32'h10, 1'b0);
    send_beat(32'h30, 1'b1);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'h20) begin
      failures++;
      $display("FAIL avg_n2 valid=%b got=%h required=1/00000020",
               vl_m, mo_m);
    end
    idle();
    @(negedge clk);
    checks++;
    if (vl_m !== 1'b0 || ec_m !== 16'd0) begin
      failures++;
      $display("FAIL avg_n2_after valid=%b errs=%0d required=0/0",
               vl_m, ec_m);
    end
  endtask

  task automatic test_rounding();
    dsel = 0;
    do_reset();
    ready = 1'b1;
    send_beat(32'hFFFF_FFFD, 1'b0);
    send_beat(32'h0, 1'b1);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL round_signed valid=%b got=%h required=1/fffffffe",
               vl_m, mo_m);
    end
    idle();
    dsel = 1;
    do_reset();
    ready = 1'b1;
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'hFFFF_FFFF, 1'b1);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL avg_unsigned valid=%b got=%h required=1/ffffffff",
               vl_m, mo_m);
    end
    idle();
  endtask

  task automatic test_framing();
    dsel = 2;
    do_reset();
    ready = 1'b1;
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b1);
    checks++;
    if (fe_m !== 1'b1 || ec_m !== 16'd1 || vl_m !== 1'b0) begin
      failures++;
      $display("FAIL early_tlast fe=%b errs=%0d valid=%b required=1/1/0",
               fe_m, ec_m, vl_m);
    end
    idle();
    @(negedge clk);
    checks++;
    if (fe_m !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse_width fe=%b required=0", fe_m);
    end
    send_beat(32'd4, 1'b0);
    send_beat(32'd8, 1'b0);
    send_beat(32'd12, 1'b0);
    send_beat(32'd16, 1'b1);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'd10) begin
      failures++;
      $display("FAIL recover_avg valid=%b got=%0d required=1/10",
               vl_m, mo_m);
    end
    for (int i = 0; i < 4; i++) send_beat(32'd1, 1'b0);
    checks++;
    if (fe_m !== 1'b1 || ec_m !== 16'd2) begin
      failures++;
      $display("FAIL missing_tlast fe=%b errs=%0d required=1/2",
               fe_m, ec_m);
    end
    send_beat(32'd1, 1'b1);
    checks++;
    if (fe_m !== 1'b0 || vl_m !== 1'b0 || ec_m !== 16'd2) begin
      failures++;
      $display("FAIL discard fe=%b valid=%b errs=%0d required=0/0/2",
               fe_m, vl_m, ec_m);
    end
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b0);
    send_beat(32'd6, 1'b1);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'd3 || ec_m !== 16'd2) begin
      failures++;
      $display("FAIL after_discard valid=%b got=%0d errs=%0d required=1/3/2",
               vl_m, mo_m, ec_m);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    int c0;
    dsel = 0;
    do_reset();
    ready = 1'b1;
    c0 = cyc;
    send_beat(32'd2, 1'b0);
    send_beat(32'd4, 1'b1);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'd3) begin
      failures++;
      $display("FAIL b2b_first valid=%b got=%0d required=1/3", vl_m, mo_m);
    end
    send_beat(32'd10, 1'b0);
    send_beat(32'd20, 1'b1);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'd15) begin
      failures++;
      $display("FAIL b2b_second valid=%b got=%0d required=1/15",
               vl_m, mo_m);
    end
    checks++;
    if (cyc - c0 !== 4) begin
      failures++;
      $display("FAIL b2b_cycles got=%0d required=4", cyc - c0);
    end
    idle();
  endtask

  task automatic test_backpressure();
    dsel = 0;
    do_reset();
    tvalid = 1'b1;
    tdata = 32'd5;
    tlast = 1'b0;
    @(negedge clk);
    tdata = 32'd7;
    tlast = 1'b1;
    @(negedge clk);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'd6) begin
      failures++;
      $display("FAIL bp_first valid=%b got=%0d required=1/6", vl_m, mo_m);
    end
    tdata = 32'd100;
    tlast = 1'b0;
    @(negedge clk);
    tdata = 32'd200;
    tlast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (tr_m !== 1'b0 || vl_m !== 1'b1 || mo_m !== 32'd6) begin
        failures++;
        $display("FAIL bp_hold%0d tready=%b valid=%b got=%0d required=0/1/6",
                 i, tr_m, vl_m, mo_m);
      end
      @(negedge clk);
    end
    ready = 1'b1;
    #1;
    checks++;
    if (tr_m !== 1'b1 || vl_m !== 1'b1 || mo_m !== 32'd6) begin
      failures++;
      $display("FAIL bp_release tready=%b valid=%b got=%0d required=1/1/6",
               tr_m, vl_m, mo_m);
    end
    @(negedge clk);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'd150) begin
      failures++;
      $display("FAIL bp_second valid=%b got=%0d required=1/150",
               vl_m, mo_m);
    end
    idle();
    @(negedge clk);
    checks++;
    if (vl_m !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain valid=%b required=0", vl_m);
    end
  endtask

  task automatic test_select();
    dsel = 2;
    do_reset();
    ready = 1'b1;
    mix_mode = 1'b1;
    sel_channel = 4'd2;
    send_beat(32'hA, 1'b0);
    sel_channel = 4'd3;
    send_beat(32'hB, 1'b0);
    send_beat(32'hC, 1'b0);
    send_beat(32'hD, 1'b1);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'hC) begin
      failures++;
      $display("FAIL select_latch valid=%b got=%h required=1/0000000c",
               vl_m, mo_m);
    end
    sel_channel = 4'd9;
    send_beat(32'h11, 1'b0);
    send_beat(32'h22, 1'b0);
    send_beat(32'h33, 1'b0);
    send_beat(32'h44, 1'b1);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'h11) begin
      failures++;
      $display("FAIL select_range valid=%b got=%h required=1/00000011",
               vl_m, mo_m);
    end
    idle();
    mix_mode = 1'b0;
    sel_channel = '0;
  endtask

  task automatic test_midframe_reset();
    dsel = 2;
    do_reset();
    ready = 1'b1;
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b1);
    ready = 1'b0;
    send_beat(32'd4, 1'b0);
    send_beat(32'd8, 1'b0);
    send_beat(32'd12, 1'b0);
    send_beat(32'd16, 1'b1);
    send_beat(32'd7, 1'b0);
    send_beat(32'd7, 1'b0);
    send_beat(32'd7, 1'b0);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'd10 || ec_m !== 16'd1) begin
      failures++;
      $display("FAIL pre_reset valid=%b got=%0d errs=%0d required=1/10/1",
               vl_m, mo_m, ec_m);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tr_m, vl_m, fe_m, mo_m, ec_m} !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h required=0",
               {tr_m, vl_m, fe_m, mo_m, ec_m});
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) send_beat(32'd1, 1'b0);
    send_beat(32'd1, 1'b1);
    checks++;
    if (vl_m !== 1'b1 || mo_m !== 32'd1 || ec_m !== 16'd0) begin
      failures++;
      $display("FAIL post_reset valid=%b got=%0d errs=%0d required=1/1/0",
               vl_m, mo_m, ec_m);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_average();
    test_rounding();
    test_framing();
    test_back_to_back();
    test_backpressure();
    test_select();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
